// File: rtl/zero_chunk_decompressor.sv
// Expands one zero-chunk-compressed page (metadata line + non-zero chunks) into a full
// 64-line page, synthesising the all-zero chunks locally.
module zero_chunk_decompressor #(
    parameter int DATA_WIDTH  = 512,
    parameter int CHUNKS      = 4,
    parameter int CHUNK_LINES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  decomp_start,
    input  logic                  rdfifo_empty,
    output logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [1:0]            rd_rresp,
    input  logic                  rd_valid,
    input  logic                  wrfifo_full,
    output logic                  wr_req,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [6:0]            decomp_size,
    output logic                  decomp_done,
    output logic                  bus_error,
    output logic [2:0]            debug_state,
    output logic [6:0]            debug_line_cnt
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_META   = 3'd1;
    localparam logic [2:0] EMIT      = 3'd2;
    localparam logic [2:0] DONE      = 3'd3;
    localparam logic [2:0] BUS_ERROR = 3'd4;

    localparam int         LINE_W     = $clog2(CHUNK_LINES);
    localparam int         CIDX_W     = $clog2(CHUNKS);
    localparam logic [6:0] PAGE_LINES = 7'(CHUNKS * CHUNK_LINES);

    // Compressed footprint: metadata line plus every chunk whose zero flag is clear.
    function automatic logic [6:0] comp_size_f(input logic [CHUNKS-1:0] meta);
        logic [6:0] n;
        n = 7'd1;
        for (int i = 0; i < CHUNKS; i++) begin
            if (!meta[i]) begin
                n = n + 7'(CHUNK_LINES);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic [2:0]            state_r, state_n;
    logic [6:0]            line_cnt_r, line_cnt_n;
    logic [CHUNKS-1:0]     meta_r, meta_n;
    logic [6:0]            size_r, size_n;
    logic [DATA_WIDTH-1:0] buf_r, buf_n;
    logic                  buf_vld_r, buf_vld_n;
    logic                  outst_r, outst_n;
    logic                  rd_req_r, rd_req_n;
    logic                  wr_req_r, wr_req_n;
    logic [DATA_WIDTH-1:0] wr_data_r, wr_data_n;
    logic                  done_r, berr_r;
    logic [2:0]            dbg_state_r;
    logic                  rd_ok_s;
    logic [CIDX_W-1:0]     chunk_s;

    assign rd_ok_s = rd_valid && outst_r;
    assign chunk_s = line_cnt_r[LINE_W +: CIDX_W];

    // Next-state and datapath decisions for the page walk.
    always_comb begin
        state_n    = state_r;
        line_cnt_n = line_cnt_r;
        meta_n     = meta_r;
        size_n     = size_r;
        buf_n      = buf_r;
        buf_vld_n  = buf_vld_r;
        outst_n    = outst_r;
        rd_req_n   = 1'b0;
        wr_req_n   = 1'b0;
        wr_data_n  = wr_data_r;
        case (state_r)
            IDLE: begin
                if (decomp_start && !rdfifo_empty) begin
                    state_n  = RD_META;
                    rd_req_n = 1'b1;
                    outst_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            RD_META: begin
                if (rd_ok_s) begin
                    outst_n = 1'b0;
                    if (rd_rresp != 2'b00) begin
                        state_n = BUS_ERROR;
                    end else begin
                        meta_n     = rd_data[CHUNKS-1:0];
                        size_n     = comp_size_f(rd_data[CHUNKS-1:0]);
                        line_cnt_n = 7'd0;
                        state_n    = EMIT;
                    end
                end else begin
                    state_n = RD_META;
                end
            end
            EMIT: begin
                if (line_cnt_r == PAGE_LINES) begin
                    state_n = DONE;
                end else if (rd_ok_s && (rd_rresp != 2'b00)) begin
                    outst_n = 1'b0;
                    state_n = BUS_ERROR;
                end else if (meta_r[chunk_s]) begin
                    if (!wrfifo_full) begin
                        wr_req_n   = 1'b1;
                        wr_data_n  = {DATA_WIDTH{1'b0}};
                        line_cnt_n = line_cnt_r + 7'd1;
                    end else begin
                        wr_req_n = 1'b0;
                    end
                end else if (rd_ok_s) begin
                    buf_n     = rd_data;
                    buf_vld_n = 1'b1;
                    outst_n   = 1'b0;
                end else if (buf_vld_r) begin
                    // A buffered line blocks further reads until it has been written out.
                    if (!wrfifo_full) begin
                        wr_req_n   = 1'b1;
                        wr_data_n  = buf_r;
                        buf_vld_n  = 1'b0;
                        line_cnt_n = line_cnt_r + 7'd1;
                    end else begin
                        buf_vld_n = 1'b1;
                    end
                end else if (!outst_r && !rdfifo_empty) begin
                    rd_req_n = 1'b1;
                    outst_n  = 1'b1;
                end else begin
                    outst_n = outst_r;
                end
            end
            DONE: begin
                if (!decomp_start) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            BUS_ERROR: begin
                state_n = BUS_ERROR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, buffer and registered-output update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            line_cnt_r  <= 7'd0;
            meta_r      <= {CHUNKS{1'b0}};
            size_r      <= 7'd0;
            buf_r       <= {DATA_WIDTH{1'b0}};
            buf_vld_r   <= 1'b0;
            outst_r     <= 1'b0;
            rd_req_r    <= 1'b0;
            wr_req_r    <= 1'b0;
            wr_data_r   <= {DATA_WIDTH{1'b0}};
            done_r      <= 1'b0;
            berr_r      <= 1'b0;
            dbg_state_r <= IDLE;
        end else begin
            state_r     <= state_n;
            line_cnt_r  <= line_cnt_n;
            meta_r      <= meta_n;
            size_r      <= size_n;
            buf_r       <= buf_n;
            buf_vld_r   <= buf_vld_n;
            outst_r     <= outst_n;
            rd_req_r    <= rd_req_n;
            wr_req_r    <= wr_req_n;
            wr_data_r   <= wr_data_n;
            done_r      <= (state_n == DONE);
            berr_r      <= (state_n == BUS_ERROR);
            dbg_state_r <= state_n;
        end
    end

    assign rd_req         = rd_req_r;
    assign wr_req         = wr_req_r;
    assign wr_data        = wr_data_r;
    assign decomp_size    = size_r;
    assign decomp_done    = done_r;
    assign bus_error      = berr_r;
    assign debug_state    = dbg_state_r;
    assign debug_line_cnt = line_cnt_r;

endmodule

// File: tb/tb_zero_chunk_decompressor.sv
// Self-checking bench: a read-FIFO responder feeds pages, a scoreboard queue holds the expected
// expanded lines, and table-driven pages plus error/reset sequences exercise the decompressor.
module tb_zero_chunk_decompressor;

    localparam int DW = 512;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    rresp;
    } rd_beat_t;

    typedef struct {
        logic [3:0] meta;
        int         full_mode;
        int         lat;
        int         exp_size;
        int         exp_rd;
        int         exp_nonconsec;
        int         drop;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          decomp_start = 1'b0;
    logic          rdfifo_empty = 1'b1;
    logic          rd_valid = 1'b0;
    logic          wrfifo_full = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic [1:0]    rd_rresp = 2'b00;
    logic          rd_req, wr_req, decomp_done, bus_error;
    logic [DW-1:0] wr_data;
    logic [6:0]    decomp_size, debug_line_cnt;
    logic [2:0]    debug_state;

    zero_chunk_decompressor dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .decomp_start(decomp_start), .rdfifo_empty(rdfifo_empty),
        .rd_req(rd_req), .rd_data(rd_data), .rd_rresp(rd_rresp), .rd_valid(rd_valid),
        .wrfifo_full(wrfifo_full), .wr_req(wr_req), .wr_data(wr_data), .decomp_size(decomp_size),
        .decomp_done(decomp_done), .bus_error(bus_error), .debug_state(debug_state),
        .debug_line_cnt(debug_line_cnt)
    );

    always #5 clk_i = ~clk_i;

    rd_beat_t      rd_q[$];
    logic [DW-1:0] exp_q[$];
    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, viol = 0, data_err = 0, nonconsec = 0;
    int full_mode = 0, lat = 0, stale_until = 0, err_cyc = -10, berr_cyc = -20, last_wr_cyc = -10;
    bit pend = 1'b0;
    int pend_cnt = 0;
    rd_beat_t hold;
    logic prev_berr = 1'b0;
    logic [DW-1:0] exp_line;

    task automatic check(input string name, input longint act, input longint expv);
        total_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", name, act, expv);
    endtask

    function automatic logic [DW-1:0] data_line(input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'hD000_0000 + 32'(k) * 32'h0000_0101 + 32'(i);
        return r;
    endfunction

    function automatic logic [DW-1:0] meta_line(input logic [3:0] m);
        logic [DW-1:0] r;
        r = '1;
        r[3:0] = m;
        return r;
    endfunction

    // Read-FIFO responder, write scoreboard and protocol monitor, one step per clock.
    initial begin
        forever begin
            @(posedge clk_i); #1;
            cyc++;
            if (bus_error && !prev_berr) berr_cyc = cyc;
            prev_berr = bus_error;
            if (wr_req) begin
                wr_cnt++;
                if (wrfifo_full) begin
                    viol++;
                    $display("FAIL wr_after_full cyc=%0d: wr_req=1 required 0", cyc);
                end
                if (cyc != last_wr_cyc + 1) nonconsec++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    data_err++;
                    $display("FAIL wr_unexpected cyc=%0d: got write, required none", cyc);
                end else begin
                    exp_line = exp_q.pop_front();
                    if (wr_data !== exp_line) begin
                        data_err++;
                        $display("FAIL wr_data cyc=%0d: got %h required %h", cyc, wr_data, exp_line);
                    end
                end
            end
            if (rd_req) begin
                rd_cnt++;
                if (rdfifo_empty || pend) begin
                    viol++;
                    $display("FAIL rd_req_illegal cyc=%0d: empty=%0d outstanding=%0d required 0/0", cyc, rdfifo_empty, pend);
                end
                if (rd_q.size() == 0) begin
                    viol++;
                    $display("FAIL rd_underflow cyc=%0d: got read, required none", cyc);
                end else begin
                    hold = rd_q.pop_front();
                    pend = 1'b1;
                    pend_cnt = lat;
                end
            end
            rd_valid = 1'b0;
            rd_rresp = 2'b00;
            rd_data  = '0;
            if (!rst_ni) begin
                pend = 1'b0;
            end else if (cyc < stale_until) begin
                rd_valid = 1'b1;
                rd_rresp = 2'b10;
                rd_data  = '1;
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = hold.data;
                    rd_rresp = hold.rresp;
                    pend     = 1'b0;
                    if (hold.rresp != 2'b00) err_cyc = cyc;
                end else begin
                    pend_cnt--;
                end
            end
            rdfifo_empty = (rd_q.size() == 0);
            case (full_mode)
                1:       wrfifo_full = ~wrfifo_full;
                2:       wrfifo_full = 1'($urandom_range(0, 1));
                default: wrfifo_full = 1'b0;
            endcase
        end
    end

    task automatic load_page(input logic [3:0] meta, input int tag);
        rd_beat_t b;
        int d;
        b.data = meta_line(meta);
        b.rresp = 2'b00;
        rd_q.push_back(b);
        d = 0;
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 16; l++) begin
                if (meta[c]) begin
                    exp_q.push_back('0);
                end else begin
                    b.data = data_line(tag * 100 + d);
                    d++;
                    rd_q.push_back(b);
                    exp_q.push_back(b.data);
                end
            end
        end
    endtask

    task automatic run_page(input vec_t v, input int tag);
        int rd0, wr0, viol0, err0, nc0, k;
        full_mode = v.full_mode;
        lat = v.lat;
        load_page(v.meta, tag);
        rd0 = rd_cnt; wr0 = wr_cnt; viol0 = viol; err0 = data_err; nc0 = nonconsec;
        decomp_start = 1'b1;
        k = 0;
        while (!decomp_done && k < 3000) begin
            @(negedge clk_i);
            k++;
            if (v.drop != 0 && k == 10) decomp_start = 1'b0;
        end
        check($sformatf("p%0d_done", tag), decomp_done, 1);
        check($sformatf("p%0d_writes", tag), wr_cnt - wr0, 64);
        check($sformatf("p%0d_reads", tag), rd_cnt - rd0, v.exp_rd);
        check($sformatf("p%0d_size", tag), decomp_size, v.exp_size);
        check($sformatf("p%0d_line_cnt", tag), debug_line_cnt, 64);
        check($sformatf("p%0d_data_errs", tag), (data_err - err0) + exp_q.size(), 0);
        check($sformatf("p%0d_protocol", tag), viol - viol0, 0);
        if (v.exp_nonconsec >= 0) check($sformatf("p%0d_write_bursts", tag), nonconsec - nc0, v.exp_nonconsec);
        if (v.drop == 0) begin
            repeat (5) @(negedge clk_i);
            check($sformatf("p%0d_done_held", tag), {decomp_done, debug_state}, {1'b1, 3'd3});
            decomp_start = 1'b0;
        end
        @(negedge clk_i);
        check($sformatf("p%0d_back_idle", tag), {decomp_done, debug_state}, {1'b0, 3'd0});
        full_mode = 0;
    endtask

    vec_t tbl[6];
    int rd0, wr0, k;

    initial begin
        tbl[0] = '{4'b1010, 0, 0, 33, 33, -1, 0};
        tbl[1] = '{4'b1111, 0, 0,  1,  1,  1, 0};
        tbl[2] = '{4'b0000, 1, 0, 65, 65, -1, 0};
        tbl[3] = '{4'b0101, 2, 2, 33, 33, -1, 0};
        tbl[4] = '{4'b0111, 0, 1, 17, 17, -1, 1};
        tbl[5] = '{4'b1100, 1, 3, 33, 33, -1, 0};

        repeat (3) @(negedge clk_i);
        check("reset_outputs", int'(|{rd_req, wr_req, wr_data, decomp_size, decomp_done, bus_error, debug_state, debug_line_cnt}), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 6; i++) run_page(tbl[i], i + 1);

        // Bus error on the fifth data read of an all-data page.
        lat = 1;
        load_page(4'b0000, 20);
        rd_q[5].rresp = 2'b10;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(data_line(2000 + i));
        rd0 = rd_cnt; wr0 = wr_cnt;
        decomp_start = 1'b1;
        k = 0;
        while (!bus_error && k < 2000) begin @(negedge clk_i); k++; end
        check("berr_raised", bus_error, 1);
        check("berr_latency", berr_cyc - err_cyc, 1);
        check("berr_state", debug_state, 4);
        repeat (30) @(negedge clk_i);
        check("berr_reads", rd_cnt - rd0, 6);
        check("berr_writes", wr_cnt - wr0, 4);
        check("berr_sticky", {bus_error, decomp_done}, {1'b1, 1'b0});
        check("berr_scoreboard", exp_q.size(), 0);
        decomp_start = 1'b0;
        rst_ni = 1'b0;
        rd_q.delete(); exp_q.delete();
        lat = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("berr_cleared_by_reset", {bus_error, debug_state}, {1'b0, 3'd0});

        // Reset mid-page, stale read response, then a fresh page.
        load_page(4'b0000, 30);
        decomp_start = 1'b1;
        k = 0;
        while (debug_line_cnt != 7'd20 && k < 2000) begin @(negedge clk_i); k++; end
        check("mid_line_cnt", debug_line_cnt, 20);
        rst_ni = 1'b0;
        decomp_start = 1'b0;
        #1;
        check("mid_reset_outputs", int'(|{rd_req, wr_req, wr_data, decomp_size, decomp_done, bus_error, debug_state, debug_line_cnt}), 0);
        rd_q.delete(); exp_q.delete();
        repeat (2) @(negedge clk_i);
        stale_until = cyc + 4;
        rst_ni = 1'b1;
        rd0 = rd_cnt;
        repeat (5) @(negedge clk_i);
        check("stale_ignored", {bus_error, debug_state}, {1'b0, 3'd0});
        check("stale_no_reads", rd_cnt - rd0, 0);
        run_page(tbl[0], 7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
